// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: EXU->LSU and LSU->WBU bus layouts, access sizes, FSM states.
package lsu_pkg;

  localparam logic [1:0] SzB = 2'd0;
  localparam logic [1:0] SzH = 2'd1;
  localparam logic [1:0] SzW = 2'd2;

  // Field order is MSB first and must match what WBU unpacks.
  typedef struct packed {
    logic        csr_we;
    logic [31:0] final_result;
    logic        gr_we;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic        brk;
    logic        excp_flush;
    logic        xret_flush;
  } lsu_wbu_t;

  typedef struct packed {
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    lsu_wbu_t    wbu;
  } exu_lsu_t;

  localparam int unsigned LsuWbuBusW = $bits(lsu_wbu_t);
  localparam int unsigned ExuLsuBusW = $bits(exu_lsu_t);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extract/extend, and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    wmask_o      = 4'b1111;
    wdata_o      = wdata_i;
    rdata_o      = sh;
    misaligned_o = 1'b0;
    case (size_i)
      SzB: begin
        wmask_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SzH: begin
        wmask_o      = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = unsigned_i ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one instruction at a time, at most one req/gnt/rvalid data-memory transaction.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  exu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ExuLsuBusW-1:0] exu_lsu_bus_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AddrW-1:0]      mem_addr_o,
  output logic [DataW-1:0]      mem_wdata_o,
  output logic [3:0]            mem_wmask_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DataW-1:0]      mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  lsu_valid_o,
  output logic [LsuWbuBusW-1:0] lsu_wbu_bus_o
);

  lsu_state_e  state_q, state_d;
  exu_lsu_t    in_bus, cap_q, cap_d, src;
  lsu_wbu_t    wbu_q, wbu_d;
  logic [3:0]  wmask;
  logic [31:0] wdata, load_data;
  logic        misaligned, in_req;
  logic        go_done, fault, use_rdata;

  assign in_bus = exu_lsu_t'(exu_lsu_bus_i);
  // In IDLE decisions are made on the incoming bus; afterwards on the captured copy.
  assign src    = (state_q == StIdle) ? in_bus : cap_q;

  lsu_align u_align (
    .size_i       (src.mem_size),
    .unsigned_i   (src.mem_unsigned),
    .addr_lo_i    (src.mem_addr[1:0]),
    .wdata_i      (src.mem_wdata),
    .rdata_i      (32'(mem_rdata_i)),
    .wmask_o      (wmask),
    .wdata_o      (wdata),
    .rdata_o      (load_data),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    wbu_d     = wbu_q;
    go_done   = 1'b0;
    fault     = 1'b0;
    use_rdata = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (exu_valid_i) begin
          cap_d = in_bus;
          if (!in_bus.mem_en) begin
            go_done = 1'b1;
          end else if (misaligned) begin
            go_done = 1'b1;
            fault   = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            go_done   = 1'b1;
            use_rdata = 1'b1;
            fault     = mem_err_i;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          go_done   = 1'b1;
          use_rdata = 1'b1;
          fault     = mem_err_i;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (go_done) begin
      state_d = StDone;
      wbu_d   = src.wbu;
      if (use_rdata && !src.mem_we && !fault) begin
        wbu_d.final_result = load_data;
      end
      if (fault) begin
        wbu_d.excp_flush = 1'b1;
        wbu_d.gr_we      = 1'b0;
        wbu_d.csr_we     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cap_q   <= '0;
      wbu_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      wbu_q   <= wbu_d;
    end
  end

  assign in_req        = (state_q == StReq);
  assign mem_req_o     = in_req;
  assign mem_we_o      = in_req & cap_q.mem_we;
  assign mem_addr_o    = in_req ? AddrW'({cap_q.mem_addr[31:2], 2'b00}) : '0;
  assign mem_wdata_o   = in_req ? DataW'(wdata) : '0;
  assign mem_wmask_o   = in_req ? wmask : 4'b0000;
  assign lsu_ready_o   = (state_q == StIdle) && !rst_i;
  assign lsu_valid_o   = (state_q == StDone);
  assign lsu_wbu_bus_o = wbu_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected WBU buses, a negedge monitor pops and compares.
`timescale 1ns / 1ps
module tb_lsu;
  import lsu_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b0;
  logic                  exu_valid_i = 1'b0;
  logic                  lsu_ready_o;
  logic [ExuLsuBusW-1:0] exu_lsu_bus_i = '0;
  logic                  mem_req_o, mem_we_o;
  logic [31:0]           mem_addr_o, mem_wdata_o;
  logic [3:0]            mem_wmask_o;
  logic                  mem_gnt_i = 1'b0;
  logic                  mem_rvalid_i = 1'b0;
  logic [31:0]           mem_rdata_i = '0;
  logic                  mem_err_i = 1'b0;
  logic                  lsu_valid_o;
  logic [LsuWbuBusW-1:0] lsu_wbu_bus_o;

  int       n_checks = 0;
  int       n_errors = 0;
  lsu_wbu_t sb[$];

  lsu #(.AddrW(32), .DataW(32)) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .exu_valid_i   (exu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .exu_lsu_bus_i (exu_lsu_bus_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wmask_o   (mem_wmask_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i),
    .lsu_valid_o   (lsu_valid_o),
    .lsu_wbu_bus_o (lsu_wbu_bus_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic lsu_wbu_t mk_wbu(input logic [31:0] fr, input logic gr_we,
                                      input logic [4:0] rd, input logic csr_we);
    lsu_wbu_t w;
    w              = '0;
    w.csr_we       = csr_we;
    w.final_result = fr;
    w.gr_we        = gr_we;
    w.rd           = rd;
    w.csr_addr     = 12'h305;
    w.csr_wdata    = 32'hCAFE_F00D;
    w.jmp_flag     = 1'b1;
    w.jmp_target   = 32'h8000_1000;
    return w;
  endfunction

  function automatic exu_lsu_t mk_exu(input logic en, input logic we, input logic [1:0] sz,
                                      input logic uns, input logic [31:0] addr,
                                      input logic [31:0] wd, input lsu_wbu_t w);
    exu_lsu_t b;
    b.mem_en       = en;
    b.mem_we       = we;
    b.mem_size     = sz;
    b.mem_unsigned = uns;
    b.mem_addr     = addr;
    b.mem_wdata    = wd;
    b.wbu          = w;
    return b;
  endfunction

  // Monitor: every lsu_valid_o pulse must match the oldest expected bus.
  always @(negedge clk_i) begin
    if (lsu_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 128'(lsu_valid_o), 128'd0);
      end else begin
        chk("wbu_bus", 128'(lsu_wbu_bus_o), 128'(sb.pop_front()));
      end
    end
  end

  initial begin
    lsu_wbu_t w, e;

    // Reset state
    rst_i = 1'b1;
    #3;
    chk("rst_ready", 128'(lsu_ready_o), 128'd0);
    chk("rst_valid", 128'(lsu_valid_o), 128'd0);
    chk("rst_req", 128'(mem_req_o), 128'd0);
    chk("rst_bus", 128'(lsu_wbu_bus_o), 128'd0);
    step();
    rst_i = 1'b0;
    step();
    chk("idle_ready", 128'(lsu_ready_o), 128'd1);

    // Non-memory op: result one cycle after accept
    w = mk_wbu(32'h0000_1234, 1'b1, 5'd5, 1'b0);
    exu_lsu_bus_i = mk_exu(1'b0, 1'b0, SzW, 1'b0, 32'h0, 32'h0, w);
    exu_valid_i = 1'b1;
    sb.push_back(w);
    step();
    exu_valid_i = 1'b0;
    chk("nonmem_valid_n1", 128'(lsu_valid_o), 128'd1);
    chk("nonmem_no_req", 128'(mem_req_o), 128'd0);
    chk("nonmem_not_ready", 128'(lsu_ready_o), 128'd0);
    step();
    chk("nonmem_pulse_end", 128'(lsu_valid_o), 128'd0);
    chk("nonmem_bus_hold", 128'(lsu_wbu_bus_o), 128'(w));

    // LB 0x80000003, gnt held off 3 cycles, rvalid 2 cycles after gnt
    w = mk_wbu(32'h0, 1'b1, 5'd7, 1'b0);
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, SzB, 1'b0, 32'h8000_0003, 32'h0, w);
    e = w;
    e.final_result = 32'hFFFF_FF80;
    sb.push_back(e);
    exu_valid_i = 1'b1;
    step();
    exu_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lb_req_held", 128'(mem_req_o), 128'd1);
      chk("lb_addr_held", 128'(mem_addr_o), 128'h8000_0000);
      step();
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("lb_wait_no_req", 128'(mem_req_o), 128'd0);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h80AB_CDEF;
    step();
    mem_rvalid_i = 1'b0;
    chk("lb_valid", 128'(lsu_valid_o), 128'd1);
    step();

    // LBU on the same data
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, SzB, 1'b1, 32'h8000_0003, 32'h0, w);
    e = w;
    e.final_result = 32'h0000_0080;
    sb.push_back(e);
    exu_valid_i = 1'b1;
    step();
    exu_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    step();

    // SH 0x80000002
    w = mk_wbu(32'hDEAD_0000, 1'b0, 5'd0, 1'b0);
    exu_lsu_bus_i = mk_exu(1'b1, 1'b1, SzH, 1'b0, 32'h8000_0002, 32'h0000_BEEF, w);
    sb.push_back(w);
    exu_valid_i = 1'b1;
    step();
    exu_valid_i = 1'b0;
    chk("sh_wmask", 128'(mem_wmask_o), 128'b1100);
    chk("sh_wdata", 128'(mem_wdata_o), 128'hBEEF_BEEF);
    chk("sh_we", 128'(mem_we_o), 128'd1);
    chk("sh_addr", 128'(mem_addr_o), 128'h8000_0000);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    chk("sh_valid_after_rvalid", 128'(lsu_valid_o), 128'd1);
    step();

    // Misaligned LW: no request, fault result next cycle
    w = mk_wbu(32'h5555_AAAA, 1'b1, 5'd9, 1'b1);
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, SzW, 1'b0, 32'h8000_0002, 32'h0, w);
    e = w;
    e.excp_flush = 1'b1;
    e.gr_we      = 1'b0;
    e.csr_we     = 1'b0;
    sb.push_back(e);
    exu_valid_i = 1'b1;
    step();
    exu_valid_i = 1'b0;
    chk("misal_no_req", 128'(mem_req_o), 128'd0);
    chk("misal_valid", 128'(lsu_valid_o), 128'd1);
    step();

    // LW bus error, gnt+rvalid in first REQ cycle (minimum latency N+2)
    w = mk_wbu(32'h0000_0042, 1'b1, 5'd3, 1'b1);
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, SzW, 1'b0, 32'h8000_0004, 32'h0, w);
    e = w;
    e.excp_flush = 1'b1;
    e.gr_we      = 1'b0;
    e.csr_we     = 1'b0;
    sb.push_back(e);
    exu_valid_i = 1'b1;
    step();
    exu_valid_i  = 1'b0;
    chk("lw_n1_not_valid", 128'(lsu_valid_o), 128'd0);
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    chk("lw_min_latency", 128'(lsu_valid_o), 128'd1);
    step();

    // Async reset during WAIT: transaction abandoned, late rvalid ignored
    w = mk_wbu(32'h0, 1'b1, 5'd4, 1'b0);
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, SzW, 1'b0, 32'h8000_0008, 32'h0, w);
    exu_valid_i = 1'b1;
    step();
    exu_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_ready", 128'(lsu_ready_o), 128'd0);
    chk("arst_valid", 128'(lsu_valid_o), 128'd0);
    chk("arst_bus", 128'(lsu_wbu_bus_o), 128'd0);
    step();
    rst_i = 1'b0;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h2222_2222;
    step();
    mem_rvalid_i = 1'b0;
    chk("late_rvalid_no_valid", 128'(lsu_valid_o), 128'd0);
    chk("late_rvalid_idle", 128'(lsu_ready_o), 128'd1);
    step();
    chk("late_rvalid_no_valid2", 128'(lsu_valid_o), 128'd0);

    repeat (2) step();
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store stage between EXU and WBU in the multi-cycle NPC.
- Accepts one instruction at a time from EXU over a valid/ready handshake.
- Performs at most one data-memory transaction over a req/gnt/rvalid interface.
- Aligns and extends load data, then presents a one-cycle lsu_valid_o pulse with the packed LSU->WBU bus.
- WBU applies no backpressure.

Parameters:
ADDR_W, 32, data address width
DATA_W, 32, data width (only 32 supported)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
exu_valid_i  in  1  EXU has an instruction
lsu_ready_o  out  1  LSU can accept (IDLE and not in reset)
exu_lsu_bus_i  in  `EXU_LSU_BUS_WIDTH  {mem_en, mem_we, mem_size[1:0], mem_unsigned, mem_addr[31:0], mem_wdata[31:0], wbu_fields[`LSU_WBU_BUS_WIDTH-1:0]}
mem_req_o  out  1  request valid, held until gnt
mem_we_o  out  1  1=store
mem_addr_o  out  32  word-aligned address (addr & ~3)
mem_wdata_o  out  32  store data replicated into lanes
mem_wmask_o  out  4  byte-lane mask
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  response (load data or store ack)
mem_rdata_i  in  32  load word
mem_err_i  in  1  bus error, qualified by mem_rvalid_i
lsu_valid_o  out  1  one-cycle result pulse to WBU
lsu_wbu_bus_o  out  `LSU_WBU_BUS_WIDTH  same layout WBU unpacks (csr_we, final_result, gr_we, rd, csr_addr, csr_wdata, jmp_flag, jmp_target, break, excp_flush, xret_flush)

Behaviour:
- Reset (async): state=IDLE; all outputs 0; captured bus cleared; lsu_ready_o=0 while rst_i high.
- Reset mid-transaction: transaction abandoned, no lsu_valid_o; a late gnt/rvalid after reset is ignored in IDLE.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE: lsu_ready_o=1. On exu_valid_i, capture exu_lsu_bus_i.
  - mem_en=0 -> DONE.
  - mem_en=1 and aligned -> REQ.
  - mem_en=1 and misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> DONE with excp_flush=1, gr_we=0, csr_we=0, no request.
- REQ: mem_req_o=1 with stable addr/we/wdata/wmask.
  - gnt=0 -> stay.
  - gnt=1 and rvalid=1 same cycle -> DONE.
  - gnt=1 only -> WAIT.
- WAIT: mem_req_o=0; stay until mem_rvalid_i; then -> DONE, latching rdata and err.
- DONE: lsu_valid_o=1 for exactly one cycle, then -> IDLE. lsu_wbu_bus_o stays stable until the next DONE.
- Minimum latency: non-memory accept at edge N, lsu_valid_o high in cycle N+1. Memory op with gnt and rvalid in the first REQ cycle: lsu_valid_o in cycle N+2.
- Store mask: byte 4'b0001<<a; half 4'b0011<<a; word 4'b1111 (a = addr[1:0]).
- Store data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Load: sh = rdata >> (8*a); byte/half sign- or zero-extended per mem_unsigned; result replaces final_result.
- Store: final_result passes through unchanged; gr_we from EXU (0 expected).
- mem_err_i=1 with rvalid: excp_flush=1, gr_we=0, csr_we=0; all other fields pass through.
- Only one outstanding transaction; rvalid in IDLE/REQ-without-gnt is ignored.

Decomposition:
- Shared header riscv_param.vh:
  - `EXU_LSU_BUS_WIDTH, `LSU_WBU_BUS_WIDTH
  - field offset macros
  - mem_size encodings (SZ_B=0, SZ_H=1, SZ_W=2)
  - LSU state encodings
- Sub-module lsu_align (combinational): wmask/wdata generation, load extract/extend, misalign detect.

Test Plan:
- Non-memory op (mem_en=0, final_result=0x1234, gr_we=1): accept at edge N -> lsu_valid_o high only in cycle N+1; bus identical to input fields; mem_req_o never asserted.
- LB at addr 0x80000003, rdata=0x80AB_CDEF, gnt held off 3 cycles, rvalid 2 cycles after gnt -> mem_addr_o=0x80000000 held during REQ; final_result=0xFFFFFF80. LBU on the same data -> 0x00000080.
- SH addr 0x80000002, wdata=0x0000BEEF -> mem_wmask_o=4'b1100, mem_wdata_o=0xBEEFBEEF, mem_we_o=1; lsu_valid_o one cycle after rvalid.
- LW at addr 0x80000002 -> no mem_req_o; lsu_valid_o next cycle with excp_flush=1, gr_we=0.
- LW with mem_rvalid_i=1, mem_err_i=1 -> excp_flush=1, gr_we=0. Async rst_i pulse during WAIT -> outputs 0 immediately; later rvalid produces no lsu_valid_o.
